// File: rtl/speicher_schnittstelle.sv
// Purpose : memory interface that serialises instruction fetch, data load and
//           data store requests onto a single-port memory bus.
// Latency : 2 edges minimum (request sampled, then MemReady sampled); a bus
//           cycle that sees no MemReady is aborted after 255 wait cycles.
// Backpressure: requests are levels held by the requester; MemReady stalls
//           the bus cycle; a completion flag stays up until its request drops.
//
// Ports:
//   Clock, Reset                       rising-edge clock, async active-high reset
//   LoadBefehlSignal / PC              instruction fetch request and address
//   LoadDatenSignal / DatenAdresse     data load request and address
//   StoreDatenSignal / StoreDaten      data store request and write data
//   Befehl, GeladeneDaten              last fetched instruction / loaded word
//   BefehlGeladen, DatenGeladen,
//   DatenGespeichert                   completion flags
//   BusFehler                          sticky timeout indication
//   MemAddr, MemWData, MemRead,
//   MemWrite, MemRData, MemReady       external memory bus
//
// Optional feature: define SPEICHER_BEFEHLSPUFFER_EN for a one-entry
// instruction buffer that lets a repeated fetch of the same PC skip the bus.
module speicher_schnittstelle (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        LoadBefehlSignal,
  input  logic        LoadDatenSignal,
  input  logic        StoreDatenSignal,
  input  logic [31:0] PC,
  input  logic [31:0] DatenAdresse,
  input  logic [31:0] StoreDaten,
  output logic [31:0] Befehl,
  output logic [31:0] GeladeneDaten,
  output logic        BefehlGeladen,
  output logic        DatenGeladen,
  output logic        DatenGespeichert,
  output logic        BusFehler,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemRData,
  input  logic        MemReady
);

  typedef enum logic [2:0] {IDLE, READ_I, READ_D, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] befehl_q, befehl_d;
  logic [31:0] daten_q, daten_d;
  logic        befehl_geladen_q, befehl_geladen_d;
  logic        daten_geladen_q, daten_geladen_d;
  logic        daten_gespeichert_q, daten_gespeichert_d;
  logic        bus_fehler_q, bus_fehler_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        bus_active;
  logic        bus_timeout;
  logic        owner_req;
  logic        buf_hit;
  logic [31:0] buf_data;

  assign bus_active = (state_q == READ_I) || (state_q == READ_D) || (state_q == WRITE);

  // The 255th consecutive wait cycle is the abort edge: the counter would
  // reach 255 there, so strobes are dropped instead of waiting further.
  assign bus_timeout = bus_active && !MemReady && (wait_cnt_q == 8'd254);

  // In DONE exactly one flag is up; it names the request that owns DONE.
  assign owner_req = (befehl_geladen_q    & LoadBefehlSignal) |
                     (daten_geladen_q     & LoadDatenSignal)  |
                     (daten_gespeichert_q & StoreDatenSignal);

`ifdef SPEICHER_BEFEHLSPUFFER_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;

  assign buf_hit  = buf_valid_q && (PC == buf_tag_q);
  assign buf_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    // Only a genuine bus read refills; a timed-out fetch leaves it alone.
    if (state_q == READ_I && MemReady) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = mem_addr_q;
      buf_data_d  = MemRData;
    end
    // Any store leaving the bus to the buffered address may have changed
    // the word, so the entry is dropped whether or not it timed out.
    if (state_q == WRITE && (MemReady || bus_timeout) && (mem_addr_q == buf_tag_q)) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 32'h0;
      buf_data_q  <= 32'h0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = 32'h0;
`endif

  always_comb begin
    state_d             = state_q;
    mem_addr_d          = mem_addr_q;
    mem_wdata_d         = mem_wdata_q;
    mem_read_d          = mem_read_q;
    mem_write_d         = mem_write_q;
    befehl_d            = befehl_q;
    daten_d             = daten_q;
    befehl_geladen_d    = befehl_geladen_q;
    daten_geladen_d     = daten_geladen_q;
    daten_gespeichert_d = daten_gespeichert_q;
    bus_fehler_d        = bus_fehler_q;
    wait_cnt_d          = wait_cnt_q;

    case (state_q)
      IDLE: begin
        // Store beats data load beats instruction fetch.
        if (StoreDatenSignal) begin
          mem_addr_d  = DatenAdresse;
          mem_wdata_d = StoreDaten;
          mem_write_d = 1'b1;
          wait_cnt_d  = 8'd0;
          state_d     = WRITE;
        end else if (LoadDatenSignal) begin
          mem_addr_d = DatenAdresse;
          mem_read_d = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = READ_D;
        end else if (LoadBefehlSignal) begin
          if (buf_hit) begin
            befehl_d         = buf_data;
            befehl_geladen_d = 1'b1;
            state_d          = DONE;
          end else begin
            mem_addr_d = PC;
            mem_read_d = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = READ_I;
          end
        end
      end

      READ_I, READ_D, WRITE: begin
        if (MemReady || bus_timeout) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
          case (state_q)
            READ_I: begin
              befehl_d         = MemReady ? MemRData : 32'h0;
              befehl_geladen_d = 1'b1;
            end
            READ_D: begin
              daten_d         = MemReady ? MemRData : 32'h0;
              daten_geladen_d = 1'b1;
            end
            default: begin
              daten_gespeichert_d = 1'b1;
            end
          endcase
          if (bus_timeout) begin
            bus_fehler_d = 1'b1;
            wait_cnt_d   = 8'hFF;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      DONE: begin
        if (!owner_req) begin
          befehl_geladen_d    = 1'b0;
          daten_geladen_d     = 1'b0;
          daten_gespeichert_d = 1'b0;
          state_d             = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q             <= IDLE;
      mem_addr_q          <= 32'h0;
      mem_wdata_q         <= 32'h0;
      mem_read_q          <= 1'b0;
      mem_write_q         <= 1'b0;
      befehl_q            <= 32'h0;
      daten_q             <= 32'h0;
      befehl_geladen_q    <= 1'b0;
      daten_geladen_q     <= 1'b0;
      daten_gespeichert_q <= 1'b0;
      bus_fehler_q        <= 1'b0;
      wait_cnt_q          <= 8'd0;
    end else begin
      state_q             <= state_d;
      mem_addr_q          <= mem_addr_d;
      mem_wdata_q         <= mem_wdata_d;
      mem_read_q          <= mem_read_d;
      mem_write_q         <= mem_write_d;
      befehl_q            <= befehl_d;
      daten_q             <= daten_d;
      befehl_geladen_q    <= befehl_geladen_d;
      daten_geladen_q     <= daten_geladen_d;
      daten_gespeichert_q <= daten_gespeichert_d;
      bus_fehler_q        <= bus_fehler_d;
      wait_cnt_q          <= wait_cnt_d;
    end
  end

  assign Befehl           = befehl_q;
  assign GeladeneDaten    = daten_q;
  assign BefehlGeladen    = befehl_geladen_q;
  assign DatenGeladen     = daten_geladen_q;
  assign DatenGespeichert = daten_gespeichert_q;
  assign BusFehler        = bus_fehler_q;
  assign MemAddr          = mem_addr_q;
  assign MemWData         = mem_wdata_q;
  assign MemRead          = mem_read_q;
  assign MemWrite         = mem_write_q;

endmodule

// File: tb/tb_speicher_schnittstelle.sv
// Bench for speicher_schnittstelle: directed scenarios plus randomized
// fetch/load/store traffic checked against a word-addressed memory model.
module tb_speicher_schnittstelle;

  logic        Clock;
  logic        Reset;
  logic        LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal;
  logic [31:0] PC, DatenAdresse, StoreDaten;
  logic [31:0] Befehl, GeladeneDaten;
  logic        BefehlGeladen, DatenGeladen, DatenGespeichert, BusFehler;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic        MemRead, MemWrite, MemReady;

  speicher_schnittstelle dut (
    .Clock(Clock), .Reset(Reset),
    .LoadBefehlSignal(LoadBefehlSignal), .LoadDatenSignal(LoadDatenSignal),
    .StoreDatenSignal(StoreDatenSignal),
    .PC(PC), .DatenAdresse(DatenAdresse), .StoreDaten(StoreDaten),
    .Befehl(Befehl), .GeladeneDaten(GeladeneDaten),
    .BefehlGeladen(BefehlGeladen), .DatenGeladen(DatenGeladen),
    .DatenGespeichert(DatenGespeichert), .BusFehler(BusFehler),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemRData(MemRData), .MemReady(MemReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: memory contents, last delivered words, sticky error,
  // and (when built with the buffer) which fetch address is buffered.
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_befehl, exp_daten;
  logic        exp_fehler;
  logic        buf_valid_m;
  logic [31:0] buf_tag_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic flag_of(input int kind);
    if (kind == 0) return BefehlGeladen;
    if (kind == 1) return DatenGeladen;
    return DatenGespeichert;
  endfunction

  task automatic set_req(input int kind, input logic v);
    if (kind == 0) LoadBefehlSignal = v;
    else if (kind == 1) LoadDatenSignal = v;
    else StoreDatenSignal = v;
  endtask

  // Raise one request and act as the memory: MemReady is given after
  // 'waits' strobe cycles. Returns the number of strobe cycles seen and the
  // edge (counted from the request-sampling edge = 1) after which the
  // completion flag was first high.
  task automatic run_xfer(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits,
                          output int strobes, output int fedge);
    @(negedge Clock);
    if (kind == 0) PC = addr;
    else begin
      DatenAdresse = addr;
      StoreDaten   = wdata;
    end
    set_req(kind, 1'b1);
    MemReady = 1'b0;
    strobes  = 0;
    fedge    = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge Clock);
      MemReady = 1'b0;
      if (flag_of(kind)) begin
        fedge = c;
        break;
      end
      if (MemRead || MemWrite) begin
        strobes++;
        chk("bus_addr", MemAddr, addr);
        chk("strobe_kind", {30'd0, MemRead, MemWrite}, (kind == 2) ? 32'd1 : 32'd2);
        if (kind == 2) chk("bus_wdata", MemWData, wdata);
        if (strobes > waits) begin
          MemReady = 1'b1;
          MemRData = rdata;
        end else begin
          MemRData = $urandom;
        end
      end
    end
    MemReady = 1'b0;
    chk("flag_seen", 32'(fedge > 0), 32'd1);
  endtask

  task automatic release_req(input int kind);
    @(negedge Clock);
    chk("flag_held", 32'(flag_of(kind)), 32'd1);
    set_req(kind, 1'b0);
    @(negedge Clock);
    chk("flag_clear", 32'(flag_of(kind)), 32'd0);
    chk("bus_idle", {30'd0, MemRead, MemWrite}, 32'd0);
  endtask

  // One complete transfer with expectations derived from the memory model:
  // a bus transfer takes waits+2 edges; 255 unanswered cycles abort it.
  task automatic do_step(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits);
    logic [31:0] rd;
    logic        hit, tmo;
    int          exp_edge, exp_str, s, e;
    rd  = mem_model.exists(addr) ? mem_model[addr] : {addr[15:0], 16'hA55A};
    hit = 1'b0;
`ifdef SPEICHER_BEFEHLSPUFFER_EN
    hit = (kind == 0) && buf_valid_m && (buf_tag_m == addr);
`endif
    tmo      = !hit && (waits >= 255);
    exp_edge = hit ? 1 : (tmo ? 256 : waits + 2);
    exp_str  = hit ? 0 : (tmo ? 255 : waits + 1);
    run_xfer(kind, addr, wdata, rd, waits, s, e);
    if (tmo) exp_fehler = 1'b1;
    if (kind == 0) begin
      exp_befehl = tmo ? 32'h0 : rd;
      if (!tmo) begin
        buf_valid_m = 1'b1;
        buf_tag_m   = addr;
      end
    end else if (kind == 1) begin
      exp_daten = tmo ? 32'h0 : rd;
    end else begin
      if (!tmo) mem_model[addr] = wdata;
      if (buf_tag_m == addr) buf_valid_m = 1'b0;
    end
    chk("flag_edge", e, exp_edge);
    chk("strobe_cycles", s, exp_str);
    chk("befehl", Befehl, exp_befehl);
    chk("geladene_daten", GeladeneDaten, exp_daten);
    chk("bus_fehler", 32'(BusFehler), 32'(exp_fehler));
    release_req(kind);
  endtask

  task automatic model_reset();
    exp_befehl  = 32'h0;
    exp_daten   = 32'h0;
    exp_fehler  = 1'b0;
    buf_valid_m = 1'b0;
    buf_tag_m   = 32'h0;
  endtask

  logic [31:0] pool [4];

  initial begin
    pool[0] = 32'h200; pool[1] = 32'h204; pool[2] = 32'h40; pool[3] = 32'h100;
    Reset = 1'b1;
    LoadBefehlSignal = 1'b0; LoadDatenSignal = 1'b0; StoreDatenSignal = 1'b0;
    PC = 32'h0; DatenAdresse = 32'h0; StoreDaten = 32'h0;
    MemRData = 32'h0; MemReady = 1'b0;
    model_reset();

    // Reset state
    @(negedge Clock);
    chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_flags", {28'd0, BefehlGeladen, DatenGeladen, DatenGespeichert, BusFehler}, 32'd0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_wdata", MemWData, 32'h0);
    chk("rst_befehl", Befehl, 32'h0);
    chk("rst_daten", GeladeneDaten, 32'h0);
    Reset = 1'b0;

    // Fetch with three wait cycles
    mem_model[32'h100] = 32'hDEADBEEF;
    do_step(0, 32'h100, 32'h0, 3);

    // Store with MemReady immediately
    do_step(2, 32'h40, 32'h12345678, 0);

    // Store and fetch raised together: store first, fetch afterwards
    @(negedge Clock);
    DatenAdresse = 32'h80; StoreDaten = 32'h0000A5A5; PC = 32'h300;
    StoreDatenSignal = 1'b1; LoadBefehlSignal = 1'b1; MemReady = 1'b1;
    @(negedge Clock);
    chk("prio_write_first", {30'd0, MemRead, MemWrite}, 32'd1);
    chk("prio_addr", MemAddr, 32'h80);
    @(negedge Clock);
    chk("prio_store_done", 32'(DatenGespeichert), 32'd1);
    StoreDatenSignal = 1'b0;
    MemRData = 32'h0BADF00D;
    @(negedge Clock);
    chk("prio_gap", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("prio_store_clr", 32'(DatenGespeichert), 32'd0);
    @(negedge Clock);
    chk("prio_fetch_next", {30'd0, MemRead, MemWrite}, 32'd2);
    chk("prio_fetch_addr", MemAddr, 32'h300);
    @(negedge Clock);
    chk("prio_fetch_done", 32'(BefehlGeladen), 32'd1);
    chk("prio_befehl", Befehl, 32'h0BADF00D);
    LoadBefehlSignal = 1'b0; MemReady = 1'b0;
    @(negedge Clock);
    chk("prio_fetch_clr", 32'(BefehlGeladen), 32'd0);
    mem_model[32'h80] = 32'h0000A5A5;
    mem_model[32'h300] = 32'h0BADF00D;
    exp_befehl = 32'h0BADF00D;
    buf_valid_m = 1'b1; buf_tag_m = 32'h300;

    // Request dropped while the bus cycle is running
    @(negedge Clock);
    PC = 32'h104; LoadBefehlSignal = 1'b1;
    @(negedge Clock);
    chk("drop_strobe", 32'(MemRead), 32'd1);
    LoadBefehlSignal = 1'b0; MemReady = 1'b1; MemRData = 32'h11223344;
    @(negedge Clock);
    MemReady = 1'b0;
    chk("drop_completes", 32'(BefehlGeladen), 32'd1);
    chk("drop_befehl", Befehl, 32'h11223344);
    @(negedge Clock);
    chk("drop_flag_low", 32'(BefehlGeladen), 32'd0);
    mem_model[32'h104] = 32'h11223344;
    exp_befehl = 32'h11223344;
    buf_tag_m = 32'h104;

    // Repeated fetch, then a store to that address, then fetch again
    mem_model[32'h200] = 32'h200C0DE0;
    do_step(0, 32'h200, 32'h0, 1);
    do_step(0, 32'h200, 32'h0, 1);
    do_step(2, 32'h200, 32'hCAFE0200, 0);
    do_step(0, 32'h200, 32'h0, 2);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      do_step($urandom_range(0, 2), pool[$urandom_range(0, 3)], $urandom, $urandom_range(0, 4));
    end

    // Timeout on a load, error stays sticky across later transfers
    do_step(1, 32'h1000, 32'h0, 1000);
    do_step(1, 32'h40, 32'h0, 1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("fehler_cleared", 32'(BusFehler), 32'd0);
    chk("rst_befehl2", Befehl, 32'h0);
    chk("rst_daten2", GeladeneDaten, 32'h0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;

    // Reset in the middle of a data read
    @(negedge Clock);
    DatenAdresse = 32'h500; LoadDatenSignal = 1'b1; MemReady = 1'b0;
    @(negedge Clock);
    chk("mid_strobe", 32'(MemRead), 32'd1);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_read", 32'(MemRead), 32'd0);
    chk("mid_rst_flag", 32'(DatenGeladen), 32'd0);
    @(negedge Clock);
    Reset = 1'b0; LoadDatenSignal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("mid_no_flag", {30'd0, DatenGeladen, MemRead}, 32'd0);
    end
    do_step(0, 32'h100, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
